// File: rtl/byte_packer.sv
// Byte-to-word packer: assembles little-endian words of BYTES bytes
// from a byte stream, with keep mask and partial-word flush on last.
module byte_packer #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid_i,
  input  logic [7:0]         i_data_i,
  input  logic               i_last_i,
  output logic               i_ready_o,
  input  logic               e_ready_i,
  output logic               e_valid_o,
  output logic [8*BYTES-1:0] e_data_o,
  output logic [BYTES-1:0]   e_keep_o,
  output logic               e_last_o
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(BYTES - 1);

  logic [8*BYTES-1:0] acc_data;
  logic [BYTES-1:0]   acc_keep;
  logic [CW-1:0]      acc_cnt;
  logic               acc_last;
  logic               acc_done;

  logic               out_valid;
  logic [8*BYTES-1:0] out_data;
  logic [BYTES-1:0]   out_keep;
  logic               out_last;

  logic               in_fire;
  logic               complete;
  logic               out_free;
  logic               move_held;
  logic               move_new;
  logic [8*BYTES-1:0] m_data;
  logic [BYTES-1:0]   m_keep;

  assign i_ready_o = !acc_done;
  assign in_fire   = i_valid_i && !acc_done;
  assign complete  = in_fire && ((acc_cnt == LAST_LANE) || i_last_i);
  assign out_free  = !out_valid || e_ready_i;
  assign move_held = acc_done && out_free;
  assign move_new  = complete && out_free;

  // Accumulator contents with the incoming byte dropped into lane acc_cnt
  always_comb begin
    m_data = acc_data;
    m_keep = acc_keep;
    for (int k = 0; k < BYTES; k++) begin
      if (acc_cnt == CW'(k)) begin
        m_data[8*k +: 8] = i_data_i;
        m_keep[k]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else if (move_held || move_new) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
    end else if (complete) begin
      acc_data <= m_data;
      acc_keep <= m_keep;
      acc_last <= i_last_i;
      acc_done <= 1'b1;
    end else if (in_fire) begin
      acc_data <= m_data;
      acc_keep <= m_keep;
      acc_cnt  <= acc_cnt + CW'(1);
    end
  end

  // A held word always has priority; no new byte can arrive while held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (move_held) begin
      out_valid <= 1'b1;
      out_data  <= acc_data;
      out_keep  <= acc_keep;
      out_last  <= acc_last;
    end else if (move_new) begin
      out_valid <= 1'b1;
      out_data  <= m_data;
      out_keep  <= m_keep;
      out_last  <= i_last_i;
    end else if (e_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign e_valid_o = out_valid;
  assign e_data_o  = out_data;
  assign e_keep_o  = out_keep;
  assign e_last_o  = out_last;

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: a byte-list reference model
// predicts words; a negedge monitor pops and compares them.
module tb_byte_packer;

  localparam int BYTES = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_valid_i;
  logic [7:0]         i_data_i;
  logic               i_last_i;
  logic               i_ready_o;
  logic               e_ready_i;
  logic               e_valid_o;
  logic [8*BYTES-1:0] e_data_o;
  logic [BYTES-1:0]   e_keep_o;
  logic               e_last_o;

  byte_packer #(.BYTES(BYTES)) dut (
    .clk(clk), .reset(reset),
    .i_valid_i(i_valid_i), .i_data_i(i_data_i),
    .i_last_i(i_last_i), .i_ready_o(i_ready_o),
    .e_ready_i(e_ready_i), .e_valid_o(e_valid_o),
    .e_data_o(e_data_o), .e_keep_o(e_keep_o),
    .e_last_o(e_last_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*BYTES-1:0] data;
    logic [BYTES-1:0]   keep;
    logic               last;
  } word_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] cur[$];
  word_t      expq[$];
  int         pop_cyc[$];

  logic  prev_hold = 1'b0;
  word_t prev_word;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: collect accepted bytes, emit a word at BYTES bytes or on last
  task automatic model_accept(input logic [7:0] b, input logic l);
    word_t w;
    cur.push_back(b);
    if (cur.size() == BYTES || l) begin
      w = '0;
      for (int k = 0; k < cur.size(); k++) begin
        w.data = w.data | ({{(8*BYTES-8){1'b0}}, cur[k]} << (8*k));
        w.keep[k] = 1'b1;
      end
      w.last = l;
      expq.push_back(w);
      cur.delete();
    end
  endtask

  always @(negedge clk) begin
    word_t act, exp;
    cyc++;
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      act = '{data: e_data_o, keep: e_keep_o, last: e_last_o};
      if (i_valid_i && i_ready_o)
        model_accept(i_data_i, i_last_i);
      if (prev_hold && e_valid_o)
        chk("hold_stable", act, prev_word);
      if (e_valid_o && e_ready_i) begin
        pop_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_word", {1'b1, act}, 0);
        end else begin
          exp = expq.pop_front();
          chk("word", act, exp);
        end
      end
      prev_hold = e_valid_o && !e_ready_i;
      prev_word = act;
    end
  end

  task automatic send(input logic [7:0] b, input logic l,
                      output int waits);
    int n;
    n = 0;
    i_valid_i = 1'b1;
    i_data_i  = b;
    i_last_i  = l;
    forever begin
      @(negedge clk);
      if (i_ready_o) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout: byte %0h never accepted", b);
        $fatal(1, "send timeout");
      end
    end
    @(posedge clk);
    #1;
    i_valid_i = 1'b0;
    i_last_i  = 1'b0;
    waits = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || e_valid_o) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  initial begin
    int w;
    int total_w;
    logic [7:0] b;
    reset     = 1'b0;
    i_valid_i = 1'b0;
    i_data_i  = '0;
    i_last_i  = 1'b0;
    e_ready_i = 1'b1;
    #1;
    chk("rst_valid", e_valid_o, 0);
    chk("rst_data", e_data_o, 0);
    chk("rst_keep", e_keep_o, 0);
    chk("rst_last", e_last_o, 0);
    chk("rst_ready", i_ready_o, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full word and one-cycle output
    send(8'h11, 0, w);
    send(8'h22, 0, w);
    send(8'h33, 0, w);
    send(8'h44, 0, w);
    chk("full_valid", e_valid_o, 1);
    chk("full_data", e_data_o, 32'h44332211);
    chk("full_keep", e_keep_o, 4'hF);
    chk("full_last", e_last_o, 0);
    @(posedge clk);
    #1;
    chk("full_one_cycle", e_valid_o, 0);

    // Partial packet
    send(8'hAA, 0, w);
    send(8'hBB, 1, w);
    chk("part_data", e_data_o, 32'h0000BBAA);
    chk("part_keep", e_keep_o, 4'h3);
    chk("part_last", e_last_o, 1);
    drain();

    // Backpressure
    e_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send(b, 0, w);
    end
    chk("bp_ready_low", i_ready_o, 0);
    chk("bp_out_word", e_data_o, 32'h04030201);
    i_valid_i = 1'b1;
    i_data_i  = 8'h09;
    repeat (3) begin
      @(negedge clk);
      chk("bp_09_blocked", i_ready_o, 0);
    end
    @(posedge clk);
    #1;
    e_ready_i = 1'b1;
    send(8'h09, 0, w);
    chk("bp_09_waited", w > 0, 1);
    send(8'h0A, 0, w);
    send(8'h0B, 0, w);
    send(8'h0C, 0, w);
    drain();

    // Streaming with no bubbles
    pop_cyc.delete();
    total_w = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      send(b, 0, w);
      total_w += w;
    end
    drain();
    chk("stream_no_bubble", total_w, 0);
    chk("stream_words", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int k = 1; k < 4; k++)
        chk("stream_spacing", pop_cyc[k] - pop_cyc[k-1], 4);

    // Last on final lane
    send(8'hC1, 0, w);
    send(8'hC2, 0, w);
    send(8'hC3, 0, w);
    send(8'hC4, 1, w);
    chk("lastlane_keep", e_keep_o, 4'hF);
    chk("lastlane_last", e_last_o, 1);
    drain();

    // Reset mid-word, with a word also waiting at the output
    e_ready_i = 1'b0;
    send(8'h01, 1, w);
    send(8'h55, 0, w);
    send(8'h66, 0, w);
    #2;
    reset = 1'b0;
    #1;
    cur.delete();
    expq.delete();
    chk("mid_rst_valid", e_valid_o, 0);
    chk("mid_rst_data", e_data_o, 0);
    chk("mid_rst_keep", e_keep_o, 0);
    chk("mid_rst_ready", i_ready_o, 1);
    @(negedge clk);
    reset = 1'b1;
    e_ready_i = 1'b1;
    @(posedge clk);
    #1;
    send(8'h77, 0, w);
    send(8'h88, 0, w);
    send(8'h99, 0, w);
    send(8'hAA, 0, w);
    chk("post_rst_data", e_data_o, 32'hAA998877);
    drain();

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          b = 8'($urandom);
          send(b, ($urandom_range(0, 5) == 0), w);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        send(8'hEE, 1, w);
      end
      begin
        for (int i = 0; i < 1500; i++) begin
          @(posedge clk);
          #1;
          e_ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join_any
    disable fork;
    e_ready_i = 1'b1;
    drain();
    chk("rand_partial_left", cur.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
